// File: rtl/spi_host_master.sv
// spi_host_master: SPI mode-0 host (MSB first) issuing single-byte register writes and 1..256-byte burst reads.
// Define SPI_HOST_INT_EN to add the synchronized int0 capture (int_i / int_clr / int_pend).
module spi_host_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  input  logic [7:0] cmd_len,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       done,
  output logic       busy,
  output logic       ss_o,
  output logic       sck_o,
  output logic       mosi_o,
  input  logic       miso_i
`ifdef SPI_HOST_INT_EN
  ,
  input  logic       int_i,
  input  logic       int_clr,
  output logic       int_pend
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned BYTE_CNT_W = 9;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [2:0]            bit_idx;
  logic [BYTE_CNT_W-1:0] bytes_left;
  logic [7:0]            tx_sh;
  logic [7:0]            rx_sh;
  logic [7:0]            wbyte;
  logic                  is_rd;
  logic                  first_byte;
  logic                  last;
  logic                  rd_pend;

  // Frame sequencer: SCK generation, shifting and handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      bytes_left <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      wbyte      <= '0;
      is_rd      <= 1'b0;
      first_byte <= 1'b0;
      last       <= 1'b0;
      rd_pend    <= 1'b0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      ss_o       <= 1'b1;
      sck_o      <= 1'b0;
      mosi_o     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      done       <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      if (rd_pend) begin
        rd_valid <= 1'b1;
        rd_data  <= rx_sh;
        rd_pend  <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            is_rd      <= cmd_rd;
            tx_sh      <= {cmd_rd, cmd_addr};
            wbyte      <= cmd_wdata;
            bytes_left <= cmd_rd ? (BYTE_CNT_W'(cmd_len) + BYTE_CNT_W'(1)) : BYTE_CNT_W'(1);
            bit_idx    <= '0;
            first_byte <= 1'b1;
            last       <= 1'b0;
            cnt        <= RELOAD;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            ss_o       <= 1'b0;
            mosi_o     <= cmd_rd;
            state      <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (cnt == '0) begin
            sck_o <= 1'b1;
            rx_sh <= {rx_sh[6:0], miso_i};
            cnt   <= RELOAD;
            state <= ST_SHIFT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            cnt <= RELOAD;
            if (!sck_o) begin
              // End of a low half-period: rise, or leave after the trailing low half of the last bit.
              if (last) begin
                state <= ST_HOLD;
              end else begin
                sck_o <= 1'b1;
                rx_sh <= {rx_sh[6:0], miso_i};
                if (bit_idx == 3'd7 && is_rd && !first_byte) begin
                  rd_pend <= 1'b1;
                end
              end
            end else begin
              sck_o <= 1'b0;
              if (bit_idx == 3'd7) begin
                bit_idx <= '0;
                if (bytes_left == '0) begin
                  mosi_o <= 1'b0;
                  last   <= 1'b1;
                end else begin
                  bytes_left <= bytes_left - BYTE_CNT_W'(1);
                  first_byte <= 1'b0;
                  tx_sh      <= is_rd ? 8'h00 : wbyte;
                  mosi_o     <= ~is_rd & wbyte[7];
                end
              end else begin
                bit_idx <= bit_idx + 3'd1;
                tx_sh   <= {tx_sh[6:0], 1'b0};
                mosi_o  <= tx_sh[6];
              end
            end
          end
        end

        ST_HOLD: begin
          if (cnt == '0) begin
            ss_o  <= 1'b1;
            done  <= 1'b1;
            cnt   <= RELOAD;
            state <= ST_GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_GAP: begin
          busy <= 1'b0;
          if (cnt == '0) begin
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          ss_o      <= 1'b1;
          sck_o     <= 1'b0;
          mosi_o    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_HOST_INT_EN
  logic [2:0] int_sync;

  // Two-flop synchronizer plus edge detect; a new edge beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      int_sync <= '0;
      int_pend <= 1'b0;
    end else begin
      int_sync <= {int_sync[1:0], int_i};
      if (int_sync[1] && !int_sync[2]) begin
        int_pend <= 1'b1;
      end else if (int_clr) begin
        int_pend <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_host_master.sv
// Self-checking bench for spi_host_master: cycle-level frame model, SPI slave model and literal frame checks.
`timescale 1ns/1ps
module tb_spi_host_master;

  localparam int CD = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rd = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic [7:0] cmd_len = '0;
  logic       miso_i = 1'b0;
  logic       cmd_ready, rd_valid, done, busy, ss_o, sck_o, mosi_o;
  logic [7:0] rd_data;
`ifdef SPI_HOST_INT_EN
  logic       int_i = 1'b0;
  logic       int_clr = 1'b0;
  logic       int_pend;
`endif

  spi_host_master #(.CLK_DIV(CD)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .busy(busy),
    .ss_o(ss_o), .sck_o(sck_o), .mosi_o(mosi_o), .miso_i(miso_i)
`ifdef SPI_HOST_INT_EN
    , .int_i(int_i), .int_clr(int_clr), .int_pend(int_pend)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame description seen by the model
  bit         chk_en = 1'b0;
  bit         have_frame = 1'b0;
  int         t_acc = 0;
  int         n_bytes = 0;
  logic       f_rd = 1'b0;
  logic [7:0] f_byte0 = '0;
  logic [7:0] f_wdata = '0;
  logic [7:0] sl_mem [0:255];

  // Monitor observations
  int         rise_cnt = 0;
  int         done_cnt = 0;
  int         done_d = 0;
  int         ss_glitch = 0;
  logic [7:0] mosi_q [$];
  logic [7:0] rd_q [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  // Slave model: presents stream bit p after p SCK falls; command-byte slot returns 0xC3.
  initial begin
    int   falls;
    int   idx;
    logic prev;
    logic [7:0] b;
    falls = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ss_o !== 1'b0) falls = 0;
      else if (prev && !sck_o) falls++;
      prev = sck_o;
      idx = falls / 8;
      b = (idx == 0) ? 8'hC3 : sl_mem[(idx - 1) % 256];
      miso_i = b[7 - (falls % 8)];
    end
  end

  // Monitor: MOSI bytes at SCK rises, read bytes, done timing, SS integrity.
  initial begin
    logic prev;
    logic [7:0] sh;
    prev = 1'b0;
    sh = '0;
    forever begin
      @(negedge clk);
      if (!prev && sck_o && !ss_o) begin
        rise_cnt++;
        sh = {sh[6:0], mosi_o};
        if (rise_cnt % 8 == 0) mosi_q.push_back(sh);
      end
      prev = sck_o;
      if (rd_valid) rd_q.push_back(rd_data);
      if (done) begin
        done_cnt++;
        done_d = cyc - t_acc;
      end
      if (busy && ss_o && !done) ss_glitch++;
    end
  end

  // Cycle model: every output derived from the offset since accept.
  initial begin
    int d, h, L, q, b;
    logic e_ready, e_busy, e_ss, e_sck, e_mosi, e_rdv, e_done;
    logic [7:0] e_byte;
    logic [7:0] last_rd;
    last_rd = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) last_rd = 8'h00;
      if (chk_en) begin
        e_ready = 1'b1; e_busy = 1'b0; e_ss = 1'b1; e_sck = 1'b0;
        e_mosi = 1'b0; e_rdv = 1'b0; e_done = 1'b0;
        if (have_frame) begin
          d = cyc - t_acc;
          L = 1 + CD * (16 * n_bytes + 2);
          if (d >= 1 && d < L + CD) begin
            e_ready = 1'b0;
            e_busy  = (d <= L);
            e_ss    = (d >= L);
            e_done  = (d == L);
            h = (d - 1) / CD;
            if (h < 16 * n_bytes) begin
              e_sck  = ((h % 2) == 1);
              e_byte = (h / 16 == 0) ? f_byte0 : (f_rd ? 8'h00 : f_wdata);
              e_mosi = e_byte[7 - ((h / 2) % 8)];
            end
            if (f_rd && d >= 2 && ((d - 2) % CD) == 0) begin
              q = (d - 2) / CD;
              if (q >= 31 && ((q - 15) % 16) == 0) begin
                b = (q - 15) / 16;
                if (b >= 1 && b <= n_bytes - 1) begin
                  e_rdv = 1'b1;
                  last_rd = sl_mem[b - 1];
                end
              end
            end
          end
        end
        tests++;
        if ({cmd_ready, busy, ss_o, sck_o, mosi_o, rd_valid, done} !==
            {e_ready, e_busy, e_ss, e_sck, e_mosi, e_rdv, e_done} || rd_data !== last_rd) begin
          fails++;
          if (fails <= 20)
            $display("FAIL cycle_model d=%0d rdy/busy/ss/sck/mosi/rdv/done got=%b rd_data=%h required=%b rd_data=%h",
                     cyc - t_acc, {cmd_ready, busy, ss_o, sck_o, mosi_o, rd_valid, done}, rd_data,
                     {e_ready, e_busy, e_ss, e_sck, e_mosi, e_rdv, e_done}, last_rd);
        end
      end
    end
  end

  task automatic issue(input logic rd, input logic [6:0] a, input logic [7:0] wd, input logic [7:0] ln);
    int k;
    k = 0;
    @(negedge clk); #1;
    while (cmd_ready !== 1'b1 && k < 2000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("issue_ready", 32'(cmd_ready), 32'h1);
    cmd_valid = 1'b1; cmd_rd = rd; cmd_addr = a; cmd_wdata = wd; cmd_len = ln;
    t_acc = cyc; f_rd = rd; f_byte0 = {rd, a}; f_wdata = wd;
    n_bytes = rd ? int'(ln) + 2 : 2;
    have_frame = 1'b1;
    @(negedge clk); #1;
    cmd_valid = 1'b0; cmd_rd = ~rd; cmd_addr = ~a; cmd_wdata = ~wd; cmd_len = ~ln;
  endtask

  task automatic wait_done(input int base);
    int k;
    k = 0;
    while (done_cnt == base && k < 20000) begin
      @(negedge clk); #1;
      k++;
    end
    tests++;
    if (done_cnt == base) begin
      fails++;
      $display("FAIL done_timeout got no done in %0d cycles, required one", k);
    end
    repeat (2 * CD + 2) @(negedge clk);
  endtask

  initial begin
    int base_rise, base_mq, base_rq, base_done, bad, k;
    for (int i = 0; i < 256; i++) sl_mem[i] = 8'(i * 7 + 3);

    // T1 reset
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 32'({cmd_ready, busy, ss_o, sck_o, mosi_o, rd_valid, done}), 32'b1010000);
    chk("reset_rd_data", 32'(rd_data), 32'h0);
`ifdef SPI_HOST_INT_EN
    chk("reset_int_pend", 32'(int_pend), 32'h0);
`endif
    #1 reset_n = 1'b1;
    chk_en = 1'b1;

    // T2 write 0x15 <- 0xA5
    base_rise = rise_cnt; base_mq = mosi_q.size(); base_rq = rd_q.size(); base_done = done_cnt;
    issue(1'b0, 7'h15, 8'hA5, 8'h07);
    wait_done(base_done);
    chk("wr_byte0", 32'(mosi_q[base_mq]), 32'h15);
    chk("wr_byte1", 32'(mosi_q[base_mq + 1]), 32'hA5);
    chk("wr_rises", 32'(rise_cnt - base_rise), 32'd16);
    chk("wr_done_cycle", 32'(done_d), 32'd137);
    chk("wr_no_rd_valid", 32'(rd_q.size() - base_rq), 32'd0);

    // T3 read 4 bytes from 0x02
    sl_mem[0] = 8'h11; sl_mem[1] = 8'h22; sl_mem[2] = 8'h33; sl_mem[3] = 8'h44;
    base_rise = rise_cnt; base_mq = mosi_q.size(); base_rq = rd_q.size(); base_done = done_cnt;
    issue(1'b1, 7'h02, 8'hFF, 8'd3);
    wait_done(base_done);
    chk("rd_byte0", 32'(mosi_q[base_mq]), 32'h82);
    chk("rd_count", 32'(rd_q.size() - base_rq), 32'd4);
    chk("rd_data0", 32'(rd_q[base_rq]), 32'h11);
    chk("rd_data1", 32'(rd_q[base_rq + 1]), 32'h22);
    chk("rd_data2", 32'(rd_q[base_rq + 2]), 32'h33);
    chk("rd_data3", 32'(rd_q[base_rq + 3]), 32'h44);
    chk("rd_rises", 32'(rise_cnt - base_rise), 32'd40);
    chk("rd_done_cycle", 32'(done_d), 32'd329);

    // T4 read 256 bytes
    for (int i = 0; i < 256; i++) sl_mem[i] = 8'(i * 7 + 3);
    base_rq = rd_q.size(); base_done = done_cnt; ss_glitch = 0;
    issue(1'b1, 7'h40, 8'h00, 8'd255);
    wait_done(base_done);
    chk("burst_count", 32'(rd_q.size() - base_rq), 32'd256);
    chk("burst_first", 32'(rd_q[base_rq]), 32'h03);
    chk("burst_last", 32'(rd_q[base_rq + 255]), 32'hFC);
    bad = 0;
    for (int i = 0; i < 256; i++) if (rd_q[base_rq + i] !== sl_mem[i]) bad++;
    chk("burst_data_errors", 32'(bad), 32'd0);
    chk("burst_ss_high_while_busy", 32'(ss_glitch), 32'd0);
    chk("burst_done_cycle", 32'(done_d), 32'd16457);

    // T5 reset mid-frame at 5th rise of byte1
    base_rise = rise_cnt; base_done = done_cnt;
    issue(1'b0, 7'h33, 8'h5A, 8'h00);
    k = 0;
    while (rise_cnt - base_rise < 13 && k < 2000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("abort_reached_rise13", 32'(rise_cnt - base_rise), 32'd13);
    chk_en = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_ss_sck", 32'({ss_o, sck_o}), 32'b10);
    chk("abort_ctrl", 32'({cmd_ready, busy, mosi_o, rd_valid, done}), 32'b10000);
    chk("abort_rd_data", 32'(rd_data), 32'h0);
    #1 reset_n = 1'b1;
    have_frame = 1'b0;
    repeat (200) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - base_done), 32'd0);
    #1 chk_en = 1'b1;
    sl_mem[0] = 8'hA1; sl_mem[1] = 8'hB2;
    base_rq = rd_q.size(); base_done = done_cnt;
    issue(1'b1, 7'h10, 8'h00, 8'd1);
    wait_done(base_done);
    chk("post_abort_count", 32'(rd_q.size() - base_rq), 32'd2);
    chk("post_abort_data0", 32'(rd_q[base_rq]), 32'hA1);
    chk("post_abort_data1", 32'(rd_q[base_rq + 1]), 32'hB2);
    chk("post_abort_done_cycle", 32'(done_d), 32'd201);

`ifdef SPI_HOST_INT_EN
    // T6 interrupt capture
    begin
      logic seen;
      seen = 1'b0;
      @(negedge clk); #1 int_i = 1'b1;
      @(negedge clk); #1 int_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        if (int_pend === 1'b1) seen = 1'b1;
      end
      chk("int_set", 32'(seen), 32'h1);
      #1 int_clr = 1'b1;
      @(negedge clk); #1 int_clr = 1'b0;
      chk("int_clear", 32'(int_pend), 32'h0);
      @(negedge clk); #1 int_i = 1'b1;
      @(negedge clk); #1 int_i = 1'b0;
      @(negedge clk); #1 int_clr = 1'b1;
      @(negedge clk); #1 int_clr = 1'b0;
      chk("int_set_beats_clear", 32'(int_pend), 32'h1);
      @(negedge clk);
      chk("int_sticky", 32'(int_pend), 32'h1);
    end
`endif

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no completion by 1ms, required completion");
    $fatal(1, "watchdog");
  end

endmodule
